mult_iter_digit: RTL and testbench



---
 rtl/mult_iter_digit.sv | 137 +++++++++++++
 tb/tb_mult_iter_digit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_iter_digit.sv
// Iterative W x W unsigned multiplier built on one D x D digit multiplier, N*N issue cycles plus one drain.
// Optional MULT_ITER_MAC_EN adds port c and makes the result a*b + c.
module mult_iter_digit #(
  parameter int W = 32,
  parameter int D = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef MULT_ITER_MAC_EN
  input  logic [W-1:0]   c,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] s
);

  localparam int N  = W / D;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0]  i_q, i_d, j_q, j_d, pi_q, pi_d, pj_q, pj_d;
  logic [2*D-1:0] p_q, p_d;
  logic           p_vld_q, p_vld_d, last_q, last_d;
  logic [2*W-1:0] acc_q, acc_d, s_q, s_d;
  logic [2*W-1:0] p_ext, p_sh, acc_sum;
  logic [D-1:0]   a_dig, b_dig;
  logic [W-1:0]   acc_init;

`ifdef MULT_ITER_MAC_EN
  assign acc_init = c;
`else
  assign acc_init = '0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;

  // Accumulate stage uses the indices captured alongside p, one cycle behind issue.
  always_comb begin
    a_dig   = a_q[int'(i_q)*D +: D];
    b_dig   = b_q[int'(j_q)*D +: D];
    p_ext   = '0;
    p_ext[2*D-1:0] = p_q;
    p_sh    = p_ext << (D * (int'(pi_q) + int'(pj_q)));
    acc_sum = p_vld_q ? (acc_q + p_sh) : acc_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    p_d     = p_q;
    pi_d    = pi_q;
    pj_d    = pj_q;
    p_vld_d = 1'b0;
    last_d  = last_q;
    acc_d   = acc_sum;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = {{W{1'b0}}, acc_init};
          i_d     = '0;
          j_d     = '0;
          last_d  = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!last_q) begin
          p_d     = (2*D)'(a_dig) * (2*D)'(b_dig);
          pi_d    = i_q;
          pj_d    = j_q;
          p_vld_d = 1'b1;
          if (i_q == IW'(N-1)) begin
            i_d = '0;
            if (j_q == IW'(N-1)) last_d = 1'b1;
            else                 j_d    = j_q + 1'b1;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          // Drain: fold in the final product and publish.
          s_d     = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      pi_q    <= '0;
      pj_q    <= '0;
      p_vld_q <= 1'b0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      p_q     <= p_d;
      pi_q    <= pi_d;
      pj_q    <= pj_d;
      p_vld_q <= p_vld_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: tb/tb_mult_iter_digit.sv
// Directed + random bench for mult_iter_digit with scoreboard queues; covers W=32/64/16 at D=16.
module tb_mult_iter_digit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULT_ITER_MAC_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, c;
  logic [63:0] s;

  logic         iv64, ir64, ov64, or64;
  logic [63:0]  a64, b64, c64;
  logic [127:0] s64;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, c16;
  logic [31:0] s16;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0]  q32[$];
  logic [127:0] q64[$];
  logic [31:0]  q16[$];

  mult_iter_digit #(.W(32), .D(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef MULT_ITER_MAC_EN
    .c(c),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s));

  mult_iter_digit #(.W(64), .D(16)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64),
`ifdef MULT_ITER_MAC_EN
    .c(c64),
`endif
    .out_valid(ov64), .out_ready(or64), .s(s64));

  mult_iter_digit #(.W(16), .D(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16),
`ifdef MULT_ITER_MAC_EN
    .c(c16),
`endif
    .out_valid(ov16), .out_ready(or16), .s(s16));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the 32-bit instance; bp > 0 holds out_ready low for bp cycles after out_valid.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                        input int bp);
    int          lat;
    logic [63:0] exp, s_hold;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    a = av; b = bv; c = cv; in_valid = 1'b1; out_ready = (bp == 0);
    q32.push_back(64'(av) * 64'(bv) + (MAC ? 64'(cv) : 64'd0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; c = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("latency32", 128'(lat), 128'd5);
    chk("done_in_ready", 128'(in_ready), 128'd0);
    exp = q32.pop_front();
    chk("s32", 128'(s), 128'(exp));
    if (bp > 0) begin
      s_hold = s;
      in_valid = 1'b1;
      repeat (bp) begin
        @(posedge clk);
        @(negedge clk);
        chk("bp_s_hold", 128'(s), 128'(s_hold));
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_hs_out_valid", 128'(out_valid), 128'd0);
    chk("post_hs_in_ready", 128'(in_ready), 128'd1);
    if (bp > 0) begin
      repeat (3) begin
        @(posedge clk);
        @(negedge clk);
        chk("no_extra_out", 128'(out_valid), 128'd0);
      end
    end
  endtask

  task automatic op64(input logic [63:0] av, input logic [63:0] bv);
    int lat;
    @(negedge clk);
    a64 = av; b64 = bv; iv64 = 1'b1;
    q64.push_back(128'(av) * 128'(bv));
    @(posedge clk);
    @(negedge clk);
    iv64 = 1'b0;
    lat = 0;
    while (!ov64 && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("latency64", 128'(lat), 128'd17);
    chk("s64", s64, q64.pop_front());
    @(posedge clk);
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv);
    int lat;
    @(negedge clk);
    a16 = av; b16 = bv; iv16 = 1'b1;
    q16.push_back(32'(av) * 32'(bv));
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("latency16", 128'(lat), 128'd2);
    chk("s16", 128'(s16), 128'(q16.pop_front()));
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = '0;
    iv64 = 1'b0; or64 = 1'b1; a64 = '0; b64 = '0; c64 = '0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; c16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_s", 128'(s), 128'd0);
    rst = 1'b0;

    run_op(32'h12345678, 32'h9ABCDEF0, 32'h0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0);
    run_op(32'h00000000, 32'hFFFFFFFF, 32'h0, 0);
    run_op(32'h00000001, 32'h80000000, 32'h0, 0);
    for (int k = 0; k < 4; k++) run_op($urandom, $urandom, 32'h0, 0);
    run_op($urandom, $urandom, 32'h0, 10);

    // Abort in the second BUSY cycle.
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01234567; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_s", 128'(s), 128'd0);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_stale", 128'(out_valid), 128'd0);
    end
    run_op(32'd3, 32'd5, 32'h0, 0);

`ifdef MULT_ITER_MAC_EN
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(32'h0, 32'h5A5A5A5A, 32'h1234, 0);
`endif

    for (int k = 0; k < 1000; k++) op64({$urandom, $urandom}, {$urandom, $urandom});
    op64(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    for (int k = 0; k < 1000; k++) op16(16'($urandom), 16'($urandom));
    op16(16'hFFFF, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
